// File: rtl/edf_queue_scheduler_if.sv
// Bundle between the EDF scheduler, the per-core queueing domain and the serializer.
//
// Handshake: the scheduler pulses queues_ready for exactly one cycle to pop the
// head of queue core_id. The queueing domain answers with a one-cycle
// queues_valid pulse. core_id stays stable from selection until that answer
// arrives or the wait times out. serializer_ready is a level that means the
// downstream side can take one packet. It is only looked at before a transaction
// starts.
interface edf_queue_scheduler_if #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int REGISTER_SIZE    = 32
);
    localparam int ID_W = (NUMBER_OF_QUEUES > 1) ? $clog2(NUMBER_OF_QUEUES) : 1;

    logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] periods;
    logic [NUMBER_OF_QUEUES-1:0]                    empty;
    logic                                           serializer_ready;
    logic                                           queues_valid;
    logic [ID_W-1:0]                                core_id;
    logic                                           queues_ready;
    logic                                           busy;
    logic                                           timeout_error;
    logic [REGISTER_SIZE-1:0]                       served_count;
    // Encoded FSM state, exported for observation: 0 IDLE, 1 ARB, 2 ISSUE, 3 WAIT.
    logic [1:0]                                     fsm_state;

    modport master (
        input  periods, empty, serializer_ready, queues_valid,
        output core_id, queues_ready, busy, timeout_error, served_count, fsm_state
    );

    modport slave (
        output periods, empty, serializer_ready, queues_valid,
        input  core_id, queues_ready, busy, timeout_error, served_count, fsm_state
    );
endinterface

// File: rtl/edf_queue_scheduler.sv
// Earliest-Deadline-First arbiter. Each core has a periodic deadline countdown.
// When the serializer can accept a packet, the scheduler selects the non-empty
// queue whose deadline is nearest and pops its head with a one-cycle ready pulse.
// It then waits a bounded time for the valid pulse.
module edf_queue_scheduler #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int REGISTER_SIZE    = 32,
    parameter int WAIT_TIMEOUT     = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    edf_queue_scheduler_if.master  bus
);
    localparam int ID_W  = (NUMBER_OF_QUEUES > 1) ? $clog2(NUMBER_OF_QUEUES) : 1;
    localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [REGISTER_SIZE-1:0] DL_ONE    = REGISTER_SIZE'(1);
    localparam logic [CNT_W-1:0]         WAIT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t                      state, state_next;
    logic [REGISTER_SIZE-1:0]    dl [NUMBER_OF_QUEUES];
    logic [NUMBER_OF_QUEUES-1:0] eligible;
    logic [ID_W-1:0]             winner;
    logic [REGISTER_SIZE-1:0]    best_dl;
    logic                        found;
    logic [ID_W-1:0]             core_id_q, core_id_next;
    logic [CNT_W-1:0]            wait_cnt, wait_cnt_next;
    logic [REGISTER_SIZE-1:0]    served_q, served_next;
    logic                        timeout_q, timeout_next;

    // Deadline countdowns run in every state. A period change is picked up only at the next reload.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            if (reset) begin
                dl[i] <= bus.periods[i];
            end else if (bus.periods[i] == '0) begin
                dl[i] <= '0;
            end else if (dl[i] <= DL_ONE) begin
                dl[i] <= bus.periods[i];
            end else begin
                dl[i] <= dl[i] - DL_ONE;
            end
        end
    end

    // A queue takes part only when it has data and its core is enabled (nonzero period).
    always_comb begin
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            eligible[i] = ~bus.empty[i] & (bus.periods[i] != '0);
        end
    end

    // Minimum-deadline search. The strict less-than keeps the lowest index on ties.
    always_comb begin
        winner  = '0;
        best_dl = '1;
        found   = 1'b0;
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            if (eligible[i] && (!found || dl[i] < best_dl)) begin
                found   = 1'b1;
                best_dl = dl[i];
                winner  = ID_W'(i);
            end
        end
    end

    // FSM, counter and status registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            core_id_q <= '0;
            wait_cnt  <= '0;
            served_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_next;
            core_id_q <= core_id_next;
            wait_cnt  <= wait_cnt_next;
            served_q  <= served_next;
            timeout_q <= timeout_next;
        end
    end

    // Next-state logic. core_id is loaded only in ARB, so the buffer read address
    // stays fixed until the transaction ends.
    always_comb begin
        state_next    = state;
        core_id_next  = core_id_q;
        wait_cnt_next = wait_cnt;
        served_next   = served_q;
        timeout_next  = timeout_q;
        case (state)
            IDLE: begin
                if (bus.serializer_ready && (|eligible)) begin
                    state_next = ARB;
                end
            end
            ARB: begin
                if (|eligible) begin
                    core_id_next = winner;
                    state_next   = ISSUE;
                end else begin
                    state_next = IDLE;
                end
            end
            ISSUE: begin
                wait_cnt_next = '0;
                state_next    = WAIT;
            end
            WAIT: begin
                if (bus.queues_valid) begin
                    served_next = served_q + DL_ONE;
                    state_next  = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    wait_cnt_next = wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The ready pulse follows directly from the single ISSUE cycle, so it can
    // never be high in two consecutive cycles.
    assign bus.queues_ready  = (state == ISSUE);
    assign bus.busy          = (state != IDLE);
    assign bus.core_id       = core_id_q;
    assign bus.served_count  = served_q;
    assign bus.timeout_error = timeout_q;
    assign bus.fsm_state     = state;
endmodule

// File: tb/tb_edf_queue_scheduler.sv
// Directed bench for edf_queue_scheduler. The expected winner of each
// arbitration comes from a closed-form deadline model and is queued, then checked
// against core_id on the pop pulse.
module tb_edf_queue_scheduler;
  localparam int N = 4;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  edf_queue_scheduler_if #(.NUMBER_OF_QUEUES(N), .REGISTER_SIZE(W)) bus();

  edf_queue_scheduler #(
    .NUMBER_OF_QUEUES(N),
    .REGISTER_SIZE(W),
    .WAIT_TIMEOUT(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.master)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;
  int last_pulse = -1;
  int first_cyc = -1;
  int core2_cnt = 0;
  bit spacing_on = 0;
  bit auto_valid = 0;
  logic ready_prev = 1'b0;
  logic [1:0] st_seen = 2'd0;
  logic [1:0] last_core = '0;
  logic [1:0] first_core = '0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference deadlines: after reset alignment, a core of period p shows p - (c mod p) at cycle c.
  function automatic int model_winner(input int c);
    int best;
    longint bd, d, p;
    best = -1;
    bd = 0;
    for (int i = 0; i < N; i++) begin
      p = longint'(bus.periods[i]);
      if (!bus.empty[i] && p != 0) begin
        d = p - (longint'(c) % p);
        if (best < 0 || d < bd) begin
          best = i;
          bd = d;
        end
      end
    end
    return best;
  endfunction

  // driver: one clock cycle, with responder and monitor folded in
  task automatic step();
    int w;
    if (!reset && st_seen == 2'd1) begin
      w = model_winner(cyc);
      if (w >= 0) exp_q.push_back(2'(w));
    end
    @(posedge clock);
    cyc++;
    #1;
    bus.queues_valid = auto_valid && ready_prev;
    @(negedge clock);
    st_seen = bus.fsm_state;
    if (bus.queues_ready) begin
      check("ready_not_back_to_back", 64'(ready_prev), 64'd0);
      check("sb_pending", 64'(exp_q.size()), 64'd1);
      if (exp_q.size() > 0) check("sb_core_id", 64'(bus.core_id), 64'(exp_q.pop_front()));
      if (spacing_on && last_pulse >= 0) check("pop_spacing", 64'(cyc - last_pulse), 64'd4);
      if (pulses == 0) begin
        first_core = bus.core_id;
        first_cyc = cyc;
      end
      if (bus.core_id == 2'd2) core2_cnt++;
      last_core = bus.core_id;
      last_pulse = cyc;
      pulses++;
    end
    if (!reset && bus.fsm_state == 2'd3) check("core_id_stable", 64'(bus.core_id), 64'(last_core));
    ready_prev = bus.queues_ready;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    cyc = 0;
    pulses = 0;
    last_pulse = -1;
    first_cyc = -1;
    core2_cnt = 0;
    exp_q.delete();
  endtask

  task automatic set_periods(input int p0, input int p1, input int p2, input int p3);
    bus.periods[0] = W'(p0);
    bus.periods[1] = W'(p1);
    bus.periods[2] = W'(p2);
    bus.periods[3] = W'(p3);
  endtask

  task automatic drain();
    spacing_on = 0;
    bus.serializer_ready = 1'b0;
    steps(10);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int nwait;
    bus.queues_valid = 1'b0;
    bus.serializer_ready = 1'b0;
    bus.empty = 4'b1111;
    set_periods(10, 20, 30, 40);

    // Step 1: reset state, all queues empty
    do_reset();
    check("rst_core_id", 64'(bus.core_id), 64'd0);
    check("rst_queues_ready", 64'(bus.queues_ready), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_timeout", 64'(bus.timeout_error), 64'd0);
    check("rst_served", 64'(bus.served_count), 64'd0);
    check("rst_state", 64'(bus.fsm_state), 64'd0);
    bus.serializer_ready = 1'b1;
    steps(45);
    check("empty_no_pops", 64'(pulses), 64'd0);
    check("empty_not_busy", 64'(bus.busy), 64'd0);
    drain();

    // Step 2: back-to-back service with valid returned one cycle after each pulse
    set_periods(40, 10, 30, 20);
    bus.empty = 4'b0000;
    bus.serializer_ready = 1'b1;
    auto_valid = 1;
    do_reset();
    spacing_on = 1;
    steps(20);
    check("first_core_id", 64'(first_core), 64'd1);
    check("first_pulse_cycle", 64'(first_cyc), 64'd2);
    bus.empty = 4'b0010;
    steps(16);
    bus.empty = 4'b0011;
    steps(16);
    bus.empty = 4'b0000;
    steps(8);
    drain();
    check("served_matches_pops", 64'(bus.served_count), 64'(pulses));

    // Step 3a: equal periods, reset-aligned deadlines tie, so index 0 wins
    set_periods(8, 8, 8, 8);
    bus.empty = 4'b0000;
    bus.serializer_ready = 1'b1;
    do_reset();
    spacing_on = 1;
    steps(6);
    check("tie_first_core", 64'(first_core), 64'd0);
    steps(20);
    drain();

    // Step 3b: a disabled core (period 0, counter held at 0) is never picked
    set_periods(8, 8, 0, 8);
    bus.empty = 4'b0011;
    bus.serializer_ready = 1'b1;
    do_reset();
    steps(30);
    check("disabled_core_never", 64'(core2_cnt), 64'd0);
    check("disabled_pops_seen", 64'(pulses > 0), 64'd1);
    drain();

    // Step 4: valid withheld, so the wait times out after 8 WAIT cycles
    set_periods(40, 10, 30, 20);
    bus.empty = 4'b0000;
    auto_valid = 0;
    bus.serializer_ready = 1'b1;
    do_reset();
    k = 0;
    while (pulses == 0 && k < 10) begin
      step();
      k++;
    end
    check("to_pulse_seen", 64'(pulses), 64'd1);
    nwait = 0;
    k = 0;
    while (k < 20) begin
      step();
      k++;
      if (bus.fsm_state == 2'd3) nwait++;
      else break;
    end
    bus.serializer_ready = 1'b0;
    check("to_wait_cycles", 64'(nwait), 64'd8);
    check("to_back_idle", 64'(bus.fsm_state), 64'd0);
    check("to_error_set", 64'(bus.timeout_error), 64'd1);
    check("to_served_unchanged", 64'(bus.served_count), 64'd0);
    steps(12);
    check("to_error_sticky", 64'(bus.timeout_error), 64'd1);
    check("sb_drained_to", 64'(exp_q.size()), 64'd0);

    // Step 5: reset in the middle of WAIT abandons the pop
    bus.serializer_ready = 1'b1;
    k = 0;
    while (bus.fsm_state != 2'd3 && k < 10) begin
      step();
      k++;
    end
    check("mid_reached_wait", 64'(bus.fsm_state), 64'd3);
    check("mid_core_before", 64'(bus.core_id), 64'd1);
    reset = 1'b1;
    exp_q.delete();
    step();
    check("mid_core_id", 64'(bus.core_id), 64'd0);
    check("mid_queues_ready", 64'(bus.queues_ready), 64'd0);
    check("mid_busy", 64'(bus.busy), 64'd0);
    check("mid_timeout", 64'(bus.timeout_error), 64'd0);
    check("mid_served", 64'(bus.served_count), 64'd0);
    check("mid_state", 64'(bus.fsm_state), 64'd0);
    pulses = 0;
    steps(2);
    check("mid_no_extra_pulse", 64'(pulses), 64'd0);

    // Step 6: the serializer gates the start; raising it starts ARB, then ISSUE
    bus.serializer_ready = 1'b0;
    auto_valid = 1;
    do_reset();
    steps(10);
    check("gate_idle_state", 64'(bus.fsm_state), 64'd0);
    check("gate_not_busy", 64'(bus.busy), 64'd0);
    check("gate_no_pops", 64'(pulses), 64'd0);
    bus.serializer_ready = 1'b1;
    step();
    check("gate_arb_next", 64'(bus.fsm_state), 64'd1);
    step();
    check("gate_issue_state", 64'(bus.fsm_state), 64'd2);
    check("gate_ready_pulse", 64'(bus.queues_ready), 64'd1);
    steps(10);
    drain();
    check("gate_served", 64'(bus.served_count), 64'(pulses));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
